// File: rtl/cc_bus_arbiter_if.sv
// Handshake bundle between the bus masters and the round-robin bus arbiter.
// Masters drive req/done; the arbiter returns grant, owner and status.
interface cc_bus_arbiter_if #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned REQ_BITS = 2
) ();

   logic [NUM_REQ-1:0]  req;
   logic [NUM_REQ-1:0]  done;
   logic [NUM_REQ-1:0]  grant;
   logic [REQ_BITS-1:0] owner;
   logic                bus_busy;
   logic                timeout_err;

   modport master (
      output req,
      output done,
      input  grant,
      input  owner,
      input  bus_busy,
      input  timeout_err
   );

   modport slave (
      input  req,
      input  done,
      output grant,
      output owner,
      output bus_busy,
      output timeout_err
   );

endinterface

// File: rtl/cc_bus_arbiter.sv
// Round-robin arbiter for the shared data bus: registered one-hot grant, one dead
// turnaround cycle between tenures, and revocation of grants held past TIMEOUT cycles.
module cc_bus_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned REQ_BITS = 2,
   parameter int unsigned TIMEOUT  = 256,
   parameter int unsigned CNT_BITS = 16
) (
   input logic              clk,
   input logic              reset_n,
   cc_bus_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

   localparam logic [CNT_BITS-1:0] TimeoutLast = CNT_BITS'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [REQ_BITS-1:0] owner_q, owner_d;
   logic [REQ_BITS-1:0] last_q, last_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                terr_q, terr_d;

   logic                found;
   logic [REQ_BITS-1:0] pick_idx;
   logic [REQ_BITS-1:0] cand;
   int unsigned         cand_sum;
   logic                rel_owner;
   logic                hit_to;

   // Search starts one past the previous winner so the last owner ranks lowest.
   always_comb begin
      found    = 1'b0;
      pick_idx = '0;
      cand     = '0;
      cand_sum = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand_sum = (32'(last_q) + i) % NUM_REQ;
         cand     = REQ_BITS'(cand_sum);
         if (!found && bus.req[cand]) begin
            found    = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign rel_owner = bus.done[owner_q] | ~bus.req[owner_q];
   assign hit_to    = (TIMEOUT != 0) && (cnt_q == TimeoutLast);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      terr_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               owner_d           = pick_idx;
               last_d            = pick_idx;
               cnt_d             = '0;
               state_d           = StGrant;
            end
         end
         StGrant: begin
            if (rel_owner || hit_to) begin
               grant_d = '0;
               state_d = StTurn;
               // A concurrent done or dropped request makes this a normal release.
               terr_d  = hit_to & ~rel_owner;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_BITS'(1);
            end
         end
         StTurn: begin
            state_d = StIdle;
         end
         default: begin
            grant_d = '0;
            state_d = StIdle;
         end
      endcase
      busy_d = |grant_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         owner_q <= '0;
         last_q  <= REQ_BITS'(NUM_REQ - 1);
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.owner       = owner_q;
   assign bus.bus_busy    = busy_q;
   assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_cc_bus_arbiter.sv
// Bench for cc_bus_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a tenure/holdoff reference model.
module tb_cc_bus_arbiter;

   localparam int NREQ = 4;
   localparam int TMO  = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   cc_bus_arbiter_if #(.NUM_REQ(NREQ), .REQ_BITS(2)) bus_if ();

   cc_bus_arbiter #(
      .NUM_REQ (NREQ),
      .REQ_BITS(2),
      .TIMEOUT (TMO),
      .CNT_BITS(16)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: who holds the bus, for how long, and how many edges must
   // pass after a release before arbitration may happen again.
   int m_own;
   int m_last;
   int m_ten;
   int m_hold;
   int m_idx;
   bit m_terr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_own  = -1;
      m_last = NREQ - 1;
      m_ten  = 0;
      m_hold = 0;
      m_idx  = 0;
      m_terr = 1'b0;
   endtask

   task automatic model_edge();
      logic [NREQ-1:0] r;
      logic [NREQ-1:0] d;
      bit to;
      bit got;
      int c;
      r      = bus_if.req;
      d      = bus_if.done;
      m_terr = 1'b0;
      got    = 1'b0;
      if (m_own >= 0) begin
         to = (TMO != 0) && (m_ten >= TMO);
         if (d[m_own] || !r[m_own] || to) begin
            m_terr = to && !d[m_own] && r[m_own];
            m_own  = -1;
            m_hold = 1;
         end else begin
            m_ten++;
         end
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (r != '0) begin
         for (int i = 1; i <= NREQ; i++) begin
            c = (m_last + i) % NREQ;
            if (!got && r[c]) begin
               got   = 1'b1;
               m_own = c;
            end
         end
         m_last = m_own;
         m_idx  = m_own;
         m_ten  = 1;
      end
   endtask

   task automatic step();
      logic [NREQ-1:0] eg;
      @(posedge clk);
      model_edge();
      #1;
      eg = (m_own >= 0) ? NREQ'(1 << m_own) : '0;
      check_eq("grant", 32'(bus_if.grant), 32'(eg));
      check_eq("owner", 32'(bus_if.owner), 32'(m_idx));
      check_eq("bus_busy", 32'(bus_if.bus_busy), 32'(eg != '0));
      check_eq("timeout_err", 32'(bus_if.timeout_err), 32'(m_terr));
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      while (bus_if.grant == '0 && n < 12) begin
         step();
         n++;
      end
      check_eq("grant_seen", 32'(bus_if.grant != '0), 32'd1);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      model_reset();
      check_eq("rst_grant", 32'(bus_if.grant), 32'd0);
      check_eq("rst_owner", 32'(bus_if.owner), 32'd0);
      check_eq("rst_busy", 32'(bus_if.bus_busy), 32'd0);
      check_eq("rst_terr", 32'(bus_if.timeout_err), 32'd0);
      reset_n = 1'b1;
   endtask

   initial begin
      int n;
      int gc;
      bus_if.req  = '0;
      bus_if.done = '0;
      model_reset();
      apply_reset();

      // Single requester, done in its third grant cycle, then regrant.
      bus_if.req = 4'b0001;
      step();
      check_eq("s1_first", 32'(bus_if.grant), 32'b0001);
      step();
      step();
      check_eq("s1_third", 32'(bus_if.grant), 32'b0001);
      bus_if.done = 4'b0001;
      step();
      bus_if.done = '0;
      check_eq("s1_rel", 32'(bus_if.grant), 32'b0000);
      step();
      check_eq("s1_gap", 32'(bus_if.grant), 32'b0000);
      step();
      check_eq("s1_regrant", 32'(bus_if.grant), 32'b0001);

      // All requesting, each done in its first cycle: 0,1,2,3,0.
      apply_reset();
      bus_if.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant(n);
         if (k > 0) check_eq("rr_gap", 32'(n), 32'd2);
         check_eq("rr_owner", 32'(bus_if.owner), 32'(k % NREQ));
         bus_if.done = bus_if.grant;
         step();
         bus_if.done = '0;
      end
      bus_if.req = '0;
      repeat (3) step();

      // Timeout on requester 2.
      bus_if.req = 4'b0100;
      wait_grant(n);
      gc = 0;
      while (bus_if.grant != '0 && gc < 20) begin
         gc++;
         step();
      end
      check_eq("to_len", 32'(gc), 32'(TMO));
      check_eq("to_err", 32'(bus_if.timeout_err), 32'd1);
      step();
      check_eq("to_err_once", 32'(bus_if.timeout_err), 32'd0);
      step();
      check_eq("to_regrant", 32'(bus_if.grant), 32'b0100);

      // done on the final allowed cycle is a normal release.
      repeat (TMO - 1) step();
      bus_if.done = 4'b0100;
      step();
      bus_if.done = '0;
      check_eq("to_done_rel", 32'(bus_if.grant), 32'b0000);
      check_eq("to_done_noerr", 32'(bus_if.timeout_err), 32'd0);
      bus_if.req = '0;
      repeat (3) step();

      // Foreign done ignored; dropping req releases.
      bus_if.req = 4'b0010;
      step();
      check_eq("s5_grant", 32'(bus_if.grant), 32'b0010);
      bus_if.done = 4'b1000;
      step();
      bus_if.done = '0;
      check_eq("s5_foreign", 32'(bus_if.grant), 32'b0010);
      bus_if.req = '0;
      step();
      check_eq("s5_drop", 32'(bus_if.grant), 32'b0000);
      bus_if.done = 4'b1000;
      step();
      bus_if.done = '0;
      check_eq("s5_turn", 32'(bus_if.grant), 32'b0000);

      // Asynchronous reset mid-tenure.
      bus_if.req = 4'b0100;
      step();
      step();
      #3;
      reset_n = 1'b0;
      #1;
      check_eq("ar_grant", 32'(bus_if.grant), 32'd0);
      check_eq("ar_busy", 32'(bus_if.bus_busy), 32'd0);
      check_eq("ar_terr", 32'(bus_if.timeout_err), 32'd0);
      repeat (2) @(posedge clk);
      #4;
      model_reset();
      bus_if.req = 4'b1010;
      reset_n = 1'b1;
      step();
      check_eq("ar_first", 32'(bus_if.grant), 32'b0010);

      // Random traffic, arbitrary req/done.
      for (int i = 0; i < 300; i++) begin
         bus_if.req  = NREQ'($urandom);
         bus_if.done = NREQ'($urandom & $urandom);
         step();
      end

      // Sticky requests with rare done, so timeouts occur.
      bus_if.req = '0;
      for (int i = 0; i < 400; i++) begin
         bus_if.req  = bus_if.req | NREQ'($urandom & $urandom & $urandom);
         bus_if.done = ($urandom_range(0, 15) == 0) ? NREQ'($urandom) : '0;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
